rom_loader: RTL
===============

# rom_loader

Parametrised, synthesizable program ROM for the uPD7800 system, replacing fixed `$readmemh` ROM models with a block RAM loaded at run time through the host download interface. The block serves CPU reads with registered, one-`CLK` latency. It tracks the loaded image size and mirrors undersized images across the decoded window by power-of-two masking. One instance serves the boot ROM; further instances serve cartridge ROM.

## Interface
Parameters:
- `AW`, 12, address width of storage; depth is 2^AW bytes.
- `BASE`, 16'h0000, CPU base address; only bits [15:AW] are compared.
- `FILL`, 8'hFF, byte driven on `DB` when not selected or not ready.

Ports:
- `CLK` in 1: sole clock.
- `RESETB` in 1: asynchronous, active-low reset.
- `A` in 16: CPU address.
- `DB` out 8: registered read data.
- `SEL` out 1: registered; `A[15:AW] == BASE[15:AW]` at the last edge.
- `DL_ACTIVE` in 1: host download in progress (level).
- `DL_WR` in 1: one-cycle write strobe, valid only while `DL_ACTIVE`=1.
- `DL_ADDR` in 25: byte offset of the write.
- `DL_DATA` in 8: write data.
- `READY` out 1: an image is loaded and reads are served from RAM.
- `OVF` out 1: sticky; a write with `DL_ADDR >= 2^AW` was dropped.
- `MASK` out AW: current mirror mask (observability).

## Operation
- States:
  - `EMPTY` (reset): `READY`=0.
  - `LOAD`: download in progress.
  - `SIZE`: one cycle to compute the mirror mask.
  - `READY`.
- State transitions:
  - `EMPTY`/`READY` → `LOAD` on the `DL_ACTIVE` rising edge. On entry: `count` ← 0, `OVF` ← 0, `READY` ← 0.
  - `LOAD` → `SIZE` on the `DL_ACTIVE` falling edge.
  - `SIZE` → `READY` if `count` != 0, else → `EMPTY`.
- Writes in `LOAD`:
  - When `DL_WR`=1 and `DL_ADDR < 2^AW`: write RAM, then `count` ← max(`count`, `DL_ADDR`+1). `count` is AW+1 bits wide, so a full image gives `count` = 2^AW.
  - When `DL_WR`=1 and `DL_ADDR >= 2^AW`: drop the write and set `OVF`=1.
  - `DL_WR` outside `LOAD` is ignored.
- Mirror mask: `MASK` = (smallest power of two ≥ `count`) − 1, saturating at 2^AW−1. Examples: `count`=1 → 0; 1024 → 0x3FF; 3000 → 0xFFF; 4096 → 0xFFF.
- Reads:
  - In `READY` with the address decoded as selected: `DB` ← RAM[`A[AW-1:0]` & `MASK`].
  - Otherwise: `DB` ← `FILL`.
- RAM contents are not cleared by reset; only state, `count`, `MASK`, `OVF` and the outputs reset.

## Timing
- Reset values: state `EMPTY`, `DB`=`FILL`, `SEL`=0, `READY`=0, `OVF`=0, `MASK`=0, `count`=0.
- Read latency: `A` sampled at edge N, `DB`/`SEL` valid after edge N. This fits inside one CPU clock phase, since `CLK` runs at 4× the CP rate.
- `DL_ACTIVE` edges are detected with one registered copy:
  - Falling edge seen at edge N → `SIZE` at N+1 → `READY`=1 at N+2.
  - Reads at N+2 use the new mask.
- Write and read to the same RAM address in the same cycle: read-first (old data). This cannot occur outside `LOAD` anyway.
- `DL_ACTIVE` rising while in `SIZE`: finish `SIZE` (one cycle), then go to `LOAD` on the next detected rising edge. The host guarantees a gap of ≥2 cycles between downloads.
- `RESETB` asserted mid-`LOAD`: immediately `EMPTY`, `READY`=0, partial image discarded (logically). After release the block waits for a fresh rising edge; a `DL_ACTIVE` already high is not treated as a rising edge.

## Structure
- Package `rom_loader_pkg`: state enum (`EMPTY`, `LOAD`, `SIZE`, `READY`) and a function `mirror_mask(count, AW)`.
- Sub-module `rom_dpram`: simple dual-port RAM, depth 2^AW, 8 bits wide, one write port, one registered read-first read port. No reset; inferable as block RAM.
- Top module: edge detector, FSM, `count`/`MASK`/`OVF` registers, address decode and output mux.

## Test plan
- Reset, no download → `READY`=0, `SEL`=0, `DB`=8'hFF; `A`=0x0000 keeps `DB`=8'hFF.
- Load 4096 bytes, `data[i] = i[7:0] ^ 8'h5A` → `READY`=1 exactly 2 cycles after the `DL_ACTIVE` fall; `MASK`=0xFFF; `A`=0x0123 → `DB`=8'h79 one cycle later.
- Load 1024 bytes → `MASK`=0x3FF; `A`=0x0400 returns `data[0]`; `A`=0x0BFF returns `data[0x3FF]`.
- Load with one write at `DL_ADDR`=0x1000 (AW=12) → `OVF`=1, RAM[0] unchanged; `OVF` clears at the next download start.
- Reset asserted halfway through a download, `DL_ACTIVE` left high → `READY`=0 and stays 0 until `DL_ACTIVE` toggles low then high.
- `BASE`=16'h8000, AW=12, image loaded → `A`=0x8010 gives `SEL`=1 with image data; `A`=0x9010 gives `SEL`=0, `DB`=8'hFF; download with zero writes → `EMPTY`.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and helpers for the run-time loadable program ROM.
//   state_t     : loader FSM states
//   mirror_mask : (smallest power of two >= count) - 1, clipped to the storage width
package rom_loader_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SIZE  = 2'd2,
    ST_READY = 2'd3
  } state_t;

  // Grows an all-ones mask until it covers every loaded byte, then clips it
  // to the address width so a full (or oversized) image maps 1:1.
  function automatic logic [15:0] mirror_mask(input logic [16:0] count,
                                               input int unsigned aw);
    logic [16:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if ((m + 17'd1) < count) m = {m[15:0], 1'b1};
    end
    m = m & ((17'd1 << aw) - 17'd1);
    return m[15:0];
  endfunction

endpackage

// File: rtl/rom_dpram.sv
// rom_dpram: simple dual-port byte RAM, depth 2^AW, no reset.
//   i_clk              : clock
//   i_wr_en/addr/data  : write port
//   i_rd_addr          : read address, sampled every edge
//   o_rd_data          : registered read data, read-first on address collision
module rom_dpram #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [0:(2**AW)-1];
  logic [7:0] r_rd_data;

  // Read and write in the same block so a collision returns the old byte.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rom_loader.sv
// rom_loader: program ROM backed by block RAM, loaded through the host download port.
//   CLK, RESETB         : clock, asynchronous active-low reset
//   A / DB / SEL        : CPU address, read data (1-cycle latency), registered decode
//   DL_ACTIVE/WR/ADDR/DATA : host download interface
//   READY, OVF, MASK    : image loaded, sticky out-of-range write, mirror mask
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int          AW   = 12,
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [7:0]  FILL = 8'hFF
) (
  input  logic          CLK,
  input  logic          RESETB,
  input  logic [15:0]   A,
  output logic [7:0]    DB,
  output logic          SEL,
  input  logic          DL_ACTIVE,
  input  logic          DL_WR,
  input  logic [24:0]   DL_ADDR,
  input  logic [7:0]    DL_DATA,
  output logic          READY,
  output logic          OVF,
  output logic [AW-1:0] MASK
);

  state_t        r_state;
  logic          r_dl_q;
  logic          r_rise;
  logic          r_fall;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_mask;
  logic          r_ovf;
  logic          r_ready;
  logic          r_sel;
  logic          r_serve;

  logic          w_in_range;
  logic          w_wr_en;
  logic [AW:0]   w_new_count;
  logic          w_sel;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    w_rd_data;

  assign w_in_range  = (DL_ADDR[24:AW] == '0);
  assign w_wr_en     = (r_state == ST_LOAD) && DL_ACTIVE && DL_WR && w_in_range;
  assign w_new_count = {1'b0, DL_ADDR[AW-1:0]} + (AW+1)'(1);
  assign w_sel       = (A[15:AW] == BASE[15:AW]);
  assign w_rd_addr   = A[AW-1:0] & r_mask;

  rom_dpram #(.AW(AW)) u_ram (
    .i_clk     (CLK),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (DL_ADDR[AW-1:0]),
    .i_wr_data (DL_DATA),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      // Edge-detect copy resets high so a DL_ACTIVE already asserted at
      // release is not mistaken for the start of a download.
      r_dl_q  <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_state <= ST_EMPTY;
      r_count <= '0;
      r_mask  <= '0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b0;
      r_sel   <= 1'b0;
      r_serve <= 1'b0;
    end else begin
      r_dl_q  <= DL_ACTIVE;
      r_rise  <= DL_ACTIVE & ~r_dl_q;
      r_fall  <= ~DL_ACTIVE & r_dl_q;
      r_sel   <= w_sel;
      r_serve <= (r_state == ST_READY) && w_sel;

      case (r_state)
        ST_EMPTY, ST_READY: begin
          if (r_rise) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (DL_ACTIVE && DL_WR) begin
            if (!w_in_range)                r_ovf   <= 1'b1;
            else if (w_new_count > r_count) r_count <= w_new_count;
          end
          if (r_fall) r_state <= ST_SIZE;
        end
        ST_SIZE: begin
          r_mask <= AW'(mirror_mask(17'(r_count), AW));
          if (r_count != '0) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end else begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // RAM output is already registered; the select/ready decision was
  // registered alongside the address, so DB lines up with SEL.
  assign DB    = r_serve ? w_rd_data : FILL;
  assign SEL   = r_sel;
  assign READY = r_ready;
  assign OVF   = r_ovf;
  assign MASK  = r_mask;

endmodule
